// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the program counter, fetches from instruction
// memory over a single-outstanding request/response port, presents the word to
// decode over valid/ready, and prefetches pc+4 while decode is stalled.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          PREFETCH_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_misaligned
);

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;
    typedef enum logic [1:0] {PF_NONE, PF_PEND, PF_RDY} pf_t;

    state_t      state, state_next;
    pf_t         pf, pf_next;
    logic [31:0] pc_next;
    logic [31:0] inst_q, inst_q_next;
    logic [31:0] pf_q, pf_q_next;
    logic        misaligned, misaligned_next;

    logic [31:0] pc_plus4;
    logic        fetch_issue;
    logic        pf_issue;
    logic        req_fire;
    logic        accept;
    logic        seq;
    logic        pf_rsp;

    // Request/handshake decode; reset forces both valids low whatever the state.
    always_comb begin
        pc_plus4        = pc + 32'd4;
        fetch_issue     = (state == REQ) && (pc[1:0] == 2'b00);
        pf_issue        = (state == HOLD) && (PREFETCH_EN != 0) &&
                          (pf == PF_NONE) && !misaligned;
        imem_req_valid  = rst_n && (fetch_issue || pf_issue);
        imem_addr       = pf_issue ? pc_plus4 : pc;
        req_fire        = imem_req_valid && imem_req_ready;
        inst_valid      = rst_n && (state == HOLD);
        inst            = inst_q;
        inst_pc         = pc;
        inst_misaligned = misaligned;
        accept          = inst_valid && inst_ready;
        seq             = (next_pc == pc_plus4);
        pf_rsp          = (pf == PF_PEND) && imem_rsp_valid;
    end

    // Next-state logic for the main FSM, the prefetch sub-state and the datapath.
    always_comb begin
        state_next      = state;
        pf_next         = pf;
        pc_next         = pc;
        inst_q_next     = inst_q;
        pf_q_next       = pf_q;
        misaligned_next = misaligned;
        case (state)
            REQ: begin
                if (pc[1:0] != 2'b00) begin
                    state_next      = HOLD;
                    misaligned_next = 1'b1;
                    inst_q_next     = '0;
                end else if (req_fire) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    inst_q_next = imem_rsp_data;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    pc_next         = next_pc;
                    misaligned_next = 1'b0;
                    pf_next         = PF_NONE;
                    if (seq && (pf == PF_RDY)) begin
                        inst_q_next = pf_q;
                    end else if (seq && pf_rsp) begin
                        inst_q_next = imem_rsp_data;
                    end else if (seq && ((pf == PF_PEND) || req_fire)) begin
                        state_next = WAIT;
                    end else if (pf_rsp) begin
                        state_next = REQ;
                    end else if ((pf == PF_PEND) || req_fire) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = REQ;
                    end
                end else if (req_fire) begin
                    pf_next = PF_PEND;
                end else if (pf_rsp) begin
                    pf_q_next = imem_rsp_data;
                    pf_next   = PF_RDY;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= REQ;
            pf         <= PF_NONE;
            pc         <= RESET_PC;
            inst_q     <= '0;
            pf_q       <= '0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            pf         <= pf_next;
            pc         <= pc_next;
            inst_q     <= inst_q_next;
            pf_q       <= pf_q_next;
            misaligned <= misaligned_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against an architectural PC/instruction model and a latency-configurable memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_misaligned;

    int nchecks = 0;
    int nerrors = 0;

    // memory model configuration (written by tests) and state (written by model)
    int          mem_lat    = 1;
    bit          lat_rand   = 1'b0;
    bit          ready_rand = 1'b0;
    int          cnt        = 0;
    logic [31:0] pend_addr  = '0;
    int          rsp_total  = 0;
    int          mon_errors = 0;
    logic [31:0] req_log[$];
    int          log_base   = 0;

    always #10 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .PREFETCH_EN(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .next_pc         (next_pc),
        .pc              (pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_misaligned (inst_misaligned)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Instruction memory: one outstanding request, in-order response after a latency.
    initial begin
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            #5;
            imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_addr);
                    rsp_total++;
                end
            end
            imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (rst_n && inst_valid && inst_misaligned && imem_req_valid) begin
                mon_errors++;
                $display("[TB] FAIL no_prefetch_misaligned: req_valid=1 addr=%h, required no request", imem_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                if (cnt != 0 || imem_addr[1:0] != 2'b00) begin
                    mon_errors++;
                    $display("[TB] FAIL mem_protocol: addr=%h outstanding=%0d, required aligned with none outstanding",
                             imem_addr, cnt);
                end
                req_log.push_back(imem_addr);
                pend_addr = imem_addr;
                cnt = lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inst_ready = 1'b0;
        next_pc = '0;
        repeat (3) step();
        log_base = req_log.size();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= limit; i++) begin
            if (inst_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        mem_lat = 1; lat_rand = 1'b0; ready_rand = 1'b0;
        rst_n = 1'b0; inst_ready = 1'b0; next_pc = '0;
        repeat (3) step();
        nchecks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            nerrors++;
            $display("[TB] FAIL reset_valids: inst_valid=%b req_valid=%b, required 0 0", inst_valid, imem_req_valid);
        end
        nchecks++;
        if (pc !== RST_PC) begin
            nerrors++;
            $display("[TB] FAIL reset_pc: got %h, required %h", pc, RST_PC);
        end
        log_base = req_log.size();
        rst_n = 1'b1;
        #1;
        nchecks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC) begin
            nerrors++;
            $display("[TB] FAIL first_req: valid=%b addr=%h, required 1 %h", imem_req_valid, imem_addr, RST_PC);
        end
        step();
        nchecks++;
        if (inst_valid !== 1'b0) begin
            nerrors++;
            $display("[TB] FAIL first_latency: inst_valid=%b one cycle after release, required 0", inst_valid);
        end
        step();
        nchecks++;
        if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== mem_word(RST_PC) || inst_misaligned !== 1'b0) begin
            nerrors++;
            $display("[TB] FAIL first_inst: valid=%b pc=%h inst=%h mis=%b, required 1 %h %h 0",
                     inst_valid, inst_pc, inst, inst_misaligned, RST_PC, mem_word(RST_PC));
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc = RST_PC;
        int got = 0;
        int n;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            inst_ready = 1'b0;
            if (inst_valid) begin
                nchecks++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    nerrors++;
                    $display("[TB] FAIL seq_order: pc=%h inst=%h, required %h %h", inst_pc, inst, exp_pc, mem_word(exp_pc));
                end
                got++;
                if (got < 4) begin
                    inst_ready = 1'b1;
                    next_pc = exp_pc + 32'd4;
                    exp_pc = exp_pc + 32'd4;
                end
            end
            if (got < 4) step();
        end
        inst_ready = 1'b0;
        nchecks++;
        if (got != 4) begin
            nerrors++;
            $display("[TB] FAIL seq_timeout: received %0d instructions, required 4", got);
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            for (int i = log_base; i < req_log.size(); i++)
                if (req_log[i] == RST_PC + 32'(4 * k)) n++;
            nchecks++;
            if (n != 1) begin
                nerrors++;
                $display("[TB] FAIL seq_req_once: addr %h requested %0d times, required 1", RST_PC + 32'(4 * k), n);
            end
        end
    endtask

    task automatic test_jump();
        bit ok;
        int base;
        mem_lat = 1;
        do_reset();
        wait_valid(20, ok);
        repeat (3) step();
        nchecks++;
        if (!ok || inst_valid !== 1'b1 || inst !== mem_word(RST_PC)) begin
            nerrors++;
            $display("[TB] FAIL jump_hold: valid=%b inst=%h, required 1 %h", inst_valid, inst, mem_word(RST_PC));
        end
        base = req_log.size();
        inst_ready = 1'b1;
        next_pc = 32'h0000_0200;
        step();
        inst_ready = 1'b0;
        wait_valid(20, ok);
        nchecks++;
        if (!ok || inst_pc !== 32'h200 || inst !== mem_word(32'h200)) begin
            nerrors++;
            $display("[TB] FAIL jump_target: valid=%b pc=%h inst=%h, required 1 00000200 %h",
                     inst_valid, inst_pc, inst, mem_word(32'h200));
        end
        nchecks++;
        if (req_log.size() != base + 1 || log_at(base) !== 32'h200) begin
            nerrors++;
            $display("[TB] FAIL jump_req: %0d requests first %h, required 1 request to 00000200",
                     req_log.size() - base, log_at(base));
        end
    endtask

    task automatic test_drain();
        bit ok;
        bit seen_req = 1'b0;
        int base;
        mem_lat = 3;
        do_reset();
        wait_valid(30, ok);
        step();
        nchecks++;
        if (log_at(req_log.size() - 1) !== RST_PC + 32'd4) begin
            nerrors++;
            $display("[TB] FAIL drain_prefetch: last request %h, required %h", log_at(req_log.size() - 1), RST_PC + 32'd4);
        end
        base = rsp_total;
        inst_ready = 1'b1;
        next_pc = 32'h0000_0300;
        step();
        inst_ready = 1'b0;
        for (int i = 0; i < 30 && inst_valid !== 1'b1; i++) begin
            if (imem_req_valid && !seen_req) begin
                seen_req = 1'b1;
                nchecks++;
                if (imem_addr !== 32'h300 || rsp_total != base + 1) begin
                    nerrors++;
                    $display("[TB] FAIL drain_order: addr=%h responses=%0d, required 00000300 %0d",
                             imem_addr, rsp_total - base, 1);
                end
            end
            step();
        end
        nchecks++;
        if (!seen_req || inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst !== mem_word(32'h300)) begin
            nerrors++;
            $display("[TB] FAIL drain_target: seen_req=%b valid=%b pc=%h inst=%h, required 1 1 00000300 %h",
                     seen_req, inst_valid, inst_pc, inst, mem_word(32'h300));
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        int base;
        mem_lat = 1;
        do_reset();
        wait_valid(20, ok);
        inst_ready = 1'b1;
        next_pc = 32'h0000_0202;
        step();
        inst_ready = 1'b0;
        base = req_log.size();
        wait_valid(20, ok);
        nchecks++;
        if (!ok || inst_misaligned !== 1'b1 || inst_pc !== 32'h202 || inst !== 32'h0) begin
            nerrors++;
            $display("[TB] FAIL misaligned_present: valid=%b mis=%b pc=%h inst=%h, required 1 1 00000202 00000000",
                     inst_valid, inst_misaligned, inst_pc, inst);
        end
        repeat (5) begin
            step();
            nchecks++;
            if (inst_valid !== 1'b1 || imem_req_valid !== 1'b0 || inst !== 32'h0) begin
                nerrors++;
                $display("[TB] FAIL misaligned_hold: valid=%b req_valid=%b inst=%h, required 1 0 00000000",
                         inst_valid, imem_req_valid, inst);
            end
        end
        nchecks++;
        if (req_log.size() != base) begin
            nerrors++;
            $display("[TB] FAIL misaligned_noreq: %0d requests, required 0", req_log.size() - base);
        end
        inst_ready = 1'b1;
        next_pc = 32'h0000_0400;
        step();
        inst_ready = 1'b0;
        wait_valid(20, ok);
        nchecks++;
        if (!ok || inst_misaligned !== 1'b0 || inst_pc !== 32'h400 || inst !== mem_word(32'h400)) begin
            nerrors++;
            $display("[TB] FAIL misaligned_clear: mis=%b pc=%h inst=%h, required 0 00000400 %h",
                     inst_misaligned, inst_pc, inst, mem_word(32'h400));
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int base;
        inst_ready = 1'b1;
        next_pc = 32'hFFFF_FFFC;
        step();
        inst_ready = 1'b0;
        wait_valid(20, ok);
        base = req_log.size();
        nchecks++;
        if (!ok || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
            nerrors++;
            $display("[TB] FAIL wrap_arrive: pc=%h inst=%h, required fffffffc %h", inst_pc, inst, mem_word(32'hFFFF_FFFC));
        end
        repeat (6) begin
            step();
            nchecks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== mem_word(32'hFFFF_FFFC)) begin
                nerrors++;
                $display("[TB] FAIL wrap_stable: valid=%b pc=%h inst=%h, required 1 fffffffc %h",
                         inst_valid, inst_pc, inst, mem_word(32'hFFFF_FFFC));
            end
        end
        nchecks++;
        if (req_log.size() != base + 1 || log_at(base) !== 32'h0) begin
            nerrors++;
            $display("[TB] FAIL wrap_prefetch: %0d requests first %h, required 1 request to 00000000",
                     req_log.size() - base, log_at(base));
        end
        inst_ready = 1'b1;
        next_pc = 32'h0;
        step();
        inst_ready = 1'b0;
        nchecks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
            nerrors++;
            $display("[TB] FAIL wrap_nobubble: valid=%b pc=%h inst=%h, required 1 00000000 %h",
                     inst_valid, inst_pc, inst, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] pc_model;
        logic [31:0] exp_inst;
        bit          exp_mis;
        int          idle = 0;
        int          r;
        lat_rand = 1'b1;
        ready_rand = 1'b1;
        do_reset();
        pc_model = RST_PC;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            inst_ready = 1'b0;
            next_pc = $urandom;
            if (inst_valid === 1'b1) begin
                idle = 0;
                exp_mis = (pc_model[1:0] != 2'b00);
                exp_inst = exp_mis ? 32'h0 : mem_word(pc_model);
                nchecks++;
                if (inst_pc !== pc_model || inst !== exp_inst || inst_misaligned !== exp_mis) begin
                    nerrors++;
                    $display("[TB] FAIL random_inst: pc=%h inst=%h mis=%b, required %h %h %b",
                             inst_pc, inst, inst_misaligned, pc_model, exp_inst, exp_mis);
                end
                if ($urandom_range(0, 2) != 0) begin
                    inst_ready = 1'b1;
                    r = int'($urandom_range(0, 9));
                    if (r < 6)      next_pc = pc_model + 32'd4;
                    else if (r < 8) next_pc = $urandom & 32'h0000_0FFC;
                    else if (r < 9) next_pc = 32'hFFFF_FFF8;
                    else            next_pc = pc_model + 32'($urandom_range(1, 3));
                    pc_model = next_pc;
                end
            end else begin
                idle++;
                inst_ready = 1'($urandom_range(0, 1));
                if (idle > 40) begin
                    nchecks++;
                    nerrors++;
                    $display("[TB] FAIL random_liveness: no instruction for %0d cycles, required at most 40", idle);
                    break;
                end
            end
            step();
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_protocol();
        nchecks++;
        if (mon_errors != 0) begin
            nerrors++;
            $display("[TB] FAIL mem_monitor: %0d protocol violations, required 0", mon_errors);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        inst_ready = 1'b0;
        next_pc = '0;
        test_reset();
        test_sequential();
        test_jump();
        test_drain();
        test_misaligned();
        test_wrap();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
